dm_stream_scheduler: RTL and testbench

- Weighted round-robin scheduler that drives `stream_select`/`stream_valid` into the datamover stream master.
- Decides which stream's queued command is presented next, holds the selection stable through the command and status handshakes, and rotates after a per-stream quantum.
- Register-programmable through the same `set_*`/`get_*` bus as the stream master.
- Includes a status watchdog with a sticky error flag.

---
 rtl/dm_stream_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_dm_stream_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stream_scheduler.sv
// rtl/dm_stream_scheduler.sv - weighted round-robin stream scheduler with status watchdog
module dm_stream_scheduler #(
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_STREAMS_WIDTH    = 2,
    parameter logic [15:0] C_BASE_ADDR        = 16'h0400,
    parameter int          C_TIMEOUT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [(1<<C_STREAMS_WIDTH)-1:0]   stream_req,
    input  logic                              cmd_fire,
    input  logic                              sts_fire,
    output logic [C_STREAMS_WIDTH-1:0]        stream_select,
    output logic                              stream_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     set_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     set_addr,
    input  logic                              set_stb,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     get_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     get_addr,
    output logic                              timeout_err,
    output logic [31:0]                       debug
);
    localparam int NS = 1 << C_STREAMS_WIDTH;
    localparam int SW = C_STREAMS_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int TW = C_TIMEOUT_WIDTH;
    localparam logic [AW-1:0] BASE = AW'(C_BASE_ADDR);

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        GRANT    = 2'd1,
        WAIT_STS = 2'd2,
        ROTATE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic          enable;
    logic [NS-1:0] mask;
    logic [3:0]    weight [NS];
    logic [TW-1:0] timeout_val;

    logic [SW-1:0] last;
    logic [3:0]    quantum_cnt;
    logic [TW-1:0] wd_cnt;
    logic [31:0]   done_cnt;
    logic [7:0]    outstanding_cnt;

    logic win, cmd_acc, sts_acc, expire;

    // Register page decode: 64-byte aligned window, word accesses only.
    logic          set_hit, ctrl_wr, timeout_wr, weight_wr;
    logic [3:0]    set_slot;
    logic [SW-1:0] set_widx;

    assign set_hit    = set_stb && (set_addr[AW-1:6] == BASE[AW-1:6]) && (set_addr[1:0] == 2'b00);
    assign set_slot   = set_addr[5:2];
    assign set_widx   = SW'(set_slot - 4'd1);
    assign ctrl_wr    = set_hit && (set_slot == 4'd0);
    assign timeout_wr = set_hit && (set_slot == 4'd12);
    assign weight_wr  = set_hit && (set_slot >= 4'd1) && (int'(set_slot) <= NS);

    // Round-robin search starting just after the last served stream.
    logic [NS-1:0] eligible;
    logic          found;
    logic [SW-1:0] winner, cand;

    always_comb begin
        eligible = enable ? (stream_req & mask) : '0;
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int i = 1; i <= NS; i++) begin
            cand = last + SW'(i);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    logic keep_ok;
    assign keep_ok = enable && stream_req[stream_select] && mask[stream_select];

    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        cmd_acc   = 1'b0;
        sts_acc   = 1'b0;
        expire    = 1'b0;
        case (state)
            ARB: begin
                if (found) begin
                    win       = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A handshake that already happened wins over a same-cycle abort.
                if (cmd_fire) begin
                    cmd_acc   = 1'b1;
                    state_nxt = WAIT_STS;
                end else if (!keep_ok) begin
                    state_nxt = ROTATE;
                end
            end
            WAIT_STS: begin
                // Completion beats a watchdog expiry on the same cycle.
                if (sts_fire) begin
                    sts_acc   = 1'b1;
                    state_nxt = (quantum_cnt != 4'd0 && keep_ok) ? GRANT : ROTATE;
                end else if (wd_cnt == TW'(1)) begin
                    expire    = 1'b1;
                    state_nxt = ROTATE;
                end
            end
            ROTATE: state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_select   <= '0;
            last            <= '1;
            quantum_cnt     <= 4'd0;
            wd_cnt          <= '0;
            done_cnt        <= 32'd0;
            outstanding_cnt <= 8'd0;
        end else begin
            if (win) begin
                stream_select <= winner;
                quantum_cnt   <= weight[winner];
            end
            // A loaded value of 0 never reaches 1, so a zero TIMEOUT disables expiry.
            if (cmd_acc) begin
                quantum_cnt <= quantum_cnt - 4'd1;
                wd_cnt      <= timeout_val;
            end else if (state == WAIT_STS && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - TW'(1);
            end
            if (sts_acc) done_cnt <= done_cnt + 32'd1;
            if (state == ROTATE) last <= stream_select;
            if (cmd_acc)
                outstanding_cnt <= outstanding_cnt + 8'd1;
            else if (sts_acc && outstanding_cnt != 8'd0)
                outstanding_cnt <= outstanding_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= 1'b0;
            mask        <= '1;
            timeout_val <= '1;
            timeout_err <= 1'b0;
            for (int m = 0; m < NS; m++) weight[m] <= 4'd1;
        end else begin
            if (ctrl_wr) begin
                enable <= set_data[0];
                mask   <= set_data[8 +: NS];
            end
            if (weight_wr) weight[set_widx] <= (set_data[3:0] == 4'd0) ? 4'd1 : set_data[3:0];
            if (timeout_wr) timeout_val <= set_data[TW-1:0];
            // Setting on expiry has priority over a software clear.
            if (expire)
                timeout_err <= 1'b1;
            else if (ctrl_wr && set_data[31])
                timeout_err <= 1'b0;
        end
    end

    logic       get_hit;
    logic [3:0] get_slot;

    assign get_hit  = (get_addr[AW-1:6] == BASE[AW-1:6]) && (get_addr[1:0] == 2'b00);
    assign get_slot = get_addr[5:2];

    always_comb begin
        get_data = DW'(32'hDEADBEEF);
        if (get_hit) begin
            if (get_slot == 4'd0) begin
                get_data           = '0;
                get_data[0]        = enable;
                get_data[8 +: NS]  = mask;
            end else if (get_slot >= 4'd1 && int'(get_slot) <= NS) begin
                get_data = DW'(weight[SW'(get_slot - 4'd1)]);
            end else if (get_slot == 4'd12) begin
                get_data = DW'(timeout_val);
            end else if (get_slot == 4'd13) begin
                get_data = DW'({state, stream_select, timeout_err});
            end else if (get_slot == 4'd14) begin
                get_data = DW'(done_cnt);
            end
        end
    end

    assign stream_valid = (state == GRANT) || (state == WAIT_STS);
    assign debug        = {state, stream_select, quantum_cnt, outstanding_cnt, {(18-SW){1'b0}}};

endmodule

// File: tb/tb_dm_stream_scheduler.sv
// tb/tb_dm_stream_scheduler.sv - self-checking bench for dm_stream_scheduler
module tb_dm_stream_scheduler;
    localparam int NS = 4;
    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stream_req;
    logic        cmd_fire, sts_fire;
    logic [1:0]  stream_select;
    logic        stream_valid;
    logic [31:0] set_data, set_addr, get_data, get_addr;
    logic        set_stb;
    logic        timeout_err;
    logic [31:0] debug;

    dm_stream_scheduler dut (
        .clk(clk), .rst(rst), .stream_req(stream_req), .cmd_fire(cmd_fire), .sts_fire(sts_fire),
        .stream_select(stream_select), .stream_valid(stream_valid), .set_data(set_data),
        .set_addr(set_addr), .set_stb(set_stb), .get_data(get_data), .get_addr(get_addr),
        .timeout_err(timeout_err), .debug(debug)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_sel;

    int       pending [NS];
    int       wt [NS];
    logic [3:0] msk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] off, input logic [31:0] data);
        set_addr = BASE + off;
        set_data = data;
        set_stb  = 1'b1;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        get_addr = addr;
        #1;
        check(tag, get_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_fire = 1'b0; sts_fire = 1'b0; stream_req = 4'b0; set_stb = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!stream_valid && n < 20) begin
            tick();
            n++;
        end
        check("grant_valid", 32'(stream_valid), 32'd1);
    endtask

    task automatic issue(input int exp_sel, input int cdly);
        cur_sel = exp_sel;
        wait_valid();
        check("grant_sel", 32'(stream_select), 32'(exp_sel));
        repeat (cdly) begin
            tick();
            check("grant_hold", {30'd0, stream_valid, 1'b0} | 32'(stream_select) << 8, 32'h2 | 32'(exp_sel) << 8);
        end
        cmd_fire = 1'b1;
        tick();
        cmd_fire = 1'b0;
    endtask

    task automatic complete(input int exp_cont, input int sdly);
        repeat (sdly) begin
            check("wait_hold", {30'd0, stream_valid, 1'b0} | 32'(stream_select) << 8, 32'h2 | 32'(cur_sel) << 8);
            tick();
        end
        sts_fire = 1'b1;
        tick();
        sts_fire = 1'b0;
        check("continue", 32'(stream_valid), 32'(exp_cont));
    endtask

    task automatic serve(input int exp_sel, input int exp_cont, input int cdly, input int sdly);
        issue(exp_sel, cdly);
        complete(exp_cont, sdly);
    endtask

    function automatic int next_after(input int l);
        for (int k = 1; k <= NS; k++) begin
            int c;
            c = (l + k) % NS;
            if (pending[c] > 0 && msk[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_req();
        for (int s = 0; s < NS; s++) stream_req[s] = (pending[s] > 0);
    endtask

    task automatic ensure_eligible();
        if (next_after(0) < 0) begin
            for (int s = NS - 1; s >= 0; s--) if (msk[s]) pending[s] = 1;
        end
    endtask

    initial begin
        int n, ex, q, cont, last_m, exp_count, s, v;
        set_addr = '0; set_data = '0; get_addr = '0;

        // Reset values and register map
        do_reset();
        check("rst_valid", 32'(stream_valid), 32'd0);
        check("rst_sel", 32'(stream_select), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_debug", debug, 32'd0);
        check_reg("rst_ctrl", BASE + 32'h00, 32'h0000_0F00);
        check_reg("rst_w0", BASE + 32'h04, 32'd1);
        check_reg("rst_timeout", BASE + 32'h30, 32'h0000_FFFF);
        check_reg("rst_status", BASE + 32'h34, 32'd0);
        check_reg("rst_count", BASE + 32'h38, 32'd0);
        check_reg("unmapped_3c", BASE + 32'h3C, 32'hDEADBEEF);
        check_reg("unmapped_14", BASE + 32'h14, 32'hDEADBEEF);
        check_reg("off_page", BASE + 32'h40, 32'hDEADBEEF);
        reg_write(32'h0C, 32'h0);
        check_reg("w2_zero_as_one", BASE + 32'h0C, 32'd1);
        reg_write(32'h10, 32'hFFFF_FFF7);
        check_reg("w3_field", BASE + 32'h10, 32'd7);
        reg_write(32'h30, 32'h0001_1234);
        check_reg("timeout_field", BASE + 32'h30, 32'h0000_1234);

        // Rotation
        do_reset();
        stream_req = 4'hF;
        reg_write(32'h00, 32'h0F01);
        serve(0, 0, 0, 2); serve(1, 0, 0, 2); serve(2, 0, 0, 2); serve(3, 0, 0, 2); serve(0, 0, 0, 2);
        check_reg("rot_count", BASE + 32'h38, 32'd5);

        // Weights
        do_reset();
        stream_req = 4'b0110;
        reg_write(32'h08, 32'd3);
        reg_write(32'h00, 32'h0F01);
        for (int r = 0; r < 2; r++) begin
            serve(1, 1, 1, 1); serve(1, 1, 0, 0); serve(1, 0, 0, 1); serve(2, 0, 1, 0);
        end

        // Mask, then mask clear mid-command
        do_reset();
        stream_req = 4'hF;
        reg_write(32'h04, 32'd2);
        reg_write(32'h00, 32'h0B01);
        serve(0, 1, 0, 1); serve(0, 0, 0, 1); serve(1, 0, 0, 1); serve(3, 0, 0, 1);
        issue(0, 0);
        reg_write(32'h00, 32'h0A01);
        complete(0, 1);
        serve(1, 0, 0, 0);
        check_reg("mask_count", BASE + 32'h38, 32'd6);

        // Weight 15 gives 15 back-to-back commands
        do_reset();
        stream_req = 4'b0011;
        reg_write(32'h04, 32'd15);
        reg_write(32'h00, 32'h0F01);
        for (int i = 0; i < 15; i++) serve(0, (i < 14) ? 1 : 0, 0, 0);
        serve(1, 0, 0, 0);

        // Watchdog
        do_reset();
        stream_req = 4'b0011;
        reg_write(32'h30, 32'd10);
        reg_write(32'h00, 32'h0F01);
        issue(0, 0);
        n = 0;
        while (!timeout_err && n < 30) begin
            tick();
            n++;
        end
        check("wd_latency", 32'(n), 32'd10);
        check("wd_rotate", 32'(stream_valid), 32'd0);
        issue(1, 0);
        reg_write(32'h00, 32'h8000_0F01);
        check("wd_clear", 32'(timeout_err), 32'd0);
        complete(0, 8);
        check("wd_sts_on_expiry", 32'(timeout_err), 32'd0);
        tick(); tick();
        check("wd_stays_clear", 32'(timeout_err), 32'd0);
        issue(0, 0);
        repeat (9) tick();
        reg_write(32'h00, 32'h8000_0F01);
        check("wd_set_wins", 32'(timeout_err), 32'd1);
        check_reg("wd_count", BASE + 32'h38, 32'd1);

        // Request drop in GRANT
        do_reset();
        stream_req = 4'b1100;
        reg_write(32'h00, 32'h0F01);
        wait_valid();
        check("drop_sel", 32'(stream_select), 32'd2);
        stream_req = 4'b1000;
        tick();
        check("drop_valid", 32'(stream_valid), 32'd0);
        serve(3, 0, 0, 0);

        // Reset mid-operation
        do_reset();
        stream_req = 4'hF;
        reg_write(32'h04, 32'd5);
        reg_write(32'h00, 32'h0F01);
        serve(0, 1, 1, 1);
        issue(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(stream_valid), 32'd0);
        check("mid_rst_sel", 32'(stream_select), 32'd0);
        check("mid_rst_debug", debug, 32'd0);
        check_reg("mid_rst_count", BASE + 32'h38, 32'd0);
        check_reg("mid_rst_w0", BASE + 32'h04, 32'd1);
        check_reg("mid_rst_ctrl", BASE + 32'h00, 32'h0000_0F00);

        // Randomized traffic against a transaction-level WRR model
        do_reset();
        msk = 4'hF;
        for (int k = 0; k < NS; k++) begin
            wt[k] = $urandom_range(1, 15);
            pending[k] = $urandom_range(0, 4);
            reg_write(32'h04 + 32'(4 * k), 32'(wt[k]));
        end
        ensure_eligible();
        drive_req();
        reg_write(32'h00, 32'h0F01);
        last_m = NS - 1; cont = 0; q = 0; ex = 0; exp_count = 0;
        for (int t = 0; t < 80; t++) begin
            if (!cont) begin
                ex = next_after(last_m);
                q = (ex >= 0) ? wt[ex] : 0;
            end
            issue(ex, $urandom_range(0, 2));
            if (ex >= 0) pending[ex]--;
            q--;
            case ($urandom_range(0, 3))
                0: begin
                    s = $urandom_range(0, NS - 1);
                    pending[s] += $urandom_range(1, 3);
                end
                1: begin
                    msk = 4'($urandom_range(1, 15));
                    reg_write(32'h00, (32'(msk) << 8) | 32'h1);
                end
                2: begin
                    s = $urandom_range(0, NS - 1);
                    v = $urandom_range(0, 15);
                    wt[s] = (v == 0) ? 1 : v;
                    reg_write(32'h04 + 32'(4 * s), 32'(v));
                end
                default: ;
            endcase
            ensure_eligible();
            drive_req();
            cont = (ex >= 0 && q > 0 && pending[ex] > 0 && msk[ex]) ? 1 : 0;
            complete(cont, $urandom_range(0, 2));
            exp_count++;
            if (!cont) last_m = ex;
        end
        check_reg("rand_count", BASE + 32'h38, 32'(exp_count));
        check("rand_err", 32'(timeout_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

endmodule
